// File: rtl/vinstru_acq_sequencer.sv
// vinstru_acq_sequencer: runs the virtual instrument through a programmed
// number of acquisitions (reset pulse, run until done, idle gap) without
// software involvement per shot. Lives in the PCIe AXI clock domain.
//
// Control pulses: start and abort are single-cycle strobes sampled on the
// rising edge of axi_aclk; there is no ready/ack. start is taken only in
// IDLE. abort is taken in any other state and overrides everything else in
// that cycle. vinstru_done is a level that is only looked at in RUN.
module vinstru_acq_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_acq,
    input  logic [31:0]      gap_cycles,
    input  logic [31:0]      timeout_cycles,
    input  logic             vinstru_done,
    output logic             vinstru_run,
    output logic             vinstru_reset,
    output logic             busy,
    output logic [CNT_W-1:0] acq_count,
    output logic             acq_pulse,
    output logic             seq_done,
    output logic             timeout_err
);

    // rst_cnt only has to reach RST_CYCLES-1
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [RC_W-1:0]   rst_cnt;
    logic [31:0]       run_timer;
    logic [31:0]       gap_cnt;
    logic [CNT_W-1:0]  num_acq_lat;
    logic [31:0]       gap_lat;
    logic [31:0]       tmo_lat;
    logic [CNT_W-1:0]  cnt_inc;
    logic              start_ok;
    logic              acq_hit;
    logic              tmo_hit;
    logic              seq_last;

    // Next completed-acquisition count; sticks at all-ones in continuous mode
    assign cnt_inc = (acq_count == {CNT_W{1'b1}}) ? acq_count : acq_count + CNT_W'(1);

    // State register
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort is checked first in every busy state
    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        acq_hit  = 1'b0;
        tmo_hit  = 1'b0;
        seq_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RST;
                    start_ok = 1'b1;
                end
            end
            S_RST: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (rst_cnt == RST_LAST) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (vinstru_done) begin
                    // done beats a timeout expiring in the same cycle
                    acq_hit = 1'b1;
                    if ((num_acq_lat != '0) && (cnt_inc == num_acq_lat)) begin
                        seq_last = 1'b1;
                        state_nx = S_IDLE;
                    end else if (gap_lat == 32'd0) begin
                        state_nx = S_RST;
                    end else begin
                        state_nx = S_GAP;
                    end
                end else if ((tmo_lat != 32'd0) && (run_timer == tmo_lat - 32'd1)) begin
                    // run has been high for tmo_lat cycles without done
                    tmo_hit  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (gap_cnt == gap_lat - 32'd1) begin
                    state_nx = S_RST;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Per-state counters restart whenever their state is (re)entered
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            rst_cnt   <= '0;
            run_timer <= 32'd0;
            gap_cnt   <= 32'd0;
        end else begin
            rst_cnt   <= (state == S_RST && state_nx == S_RST) ? rst_cnt + RC_W'(1) : '0;
            run_timer <= (state == S_RUN && state_nx == S_RUN) ? run_timer + 32'd1 : 32'd0;
            gap_cnt   <= (state == S_GAP && state_nx == S_GAP) ? gap_cnt + 32'd1 : 32'd0;
        end
    end

    // Sequence settings are frozen when a start is accepted
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            num_acq_lat <= '0;
            gap_lat     <= 32'd0;
            tmo_lat     <= 32'd0;
        end else if (start_ok) begin
            num_acq_lat <= num_acq;
            gap_lat     <= gap_cycles;
            tmo_lat     <= timeout_cycles;
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            vinstru_run   <= 1'b0;
            vinstru_reset <= 1'b0;
            busy          <= 1'b0;
            acq_count     <= '0;
            acq_pulse     <= 1'b0;
            seq_done      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            vinstru_run   <= (state_nx == S_RUN);
            vinstru_reset <= (state_nx == S_RST);
            busy          <= (state_nx != S_IDLE);
            acq_pulse     <= acq_hit;
            if (start_ok) begin
                acq_count   <= '0;
                seq_done    <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (acq_hit) begin
                    acq_count <= cnt_inc;
                end
                if (seq_last) begin
                    seq_done <= 1'b1;
                end
                if (tmo_hit) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vinstru_acq_sequencer.sv
// Bench for vinstru_acq_sequencer: a reference model expands each planned
// sequence into the list of events it must produce (pulse widths, gaps,
// counts, final status); a monitor measures the same events on the pins.
`timescale 1ns/1ps
module tb_vinstru_acq_sequencer;

    localparam int RC = 4;
    localparam int CW = 16;
    localparam logic [3:0] K_START = 4'd1;
    localparam logic [3:0] K_RST   = 4'd2;
    localparam logic [3:0] K_RUN   = 4'd3;
    localparam logic [3:0] K_PULSE = 4'd4;
    localparam logic [3:0] K_GAP   = 4'd5;
    localparam logic [3:0] K_END   = 4'd6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          start;
    logic          abort = 1'b0;
    logic          done = 1'b0;
    logic [CW-1:0] num_acq;
    logic [31:0]   gap_cycles;
    logic [31:0]   timeout_cycles;
    logic          vinstru_run;
    logic          vinstru_reset;
    logic          busy;
    logic [CW-1:0] acq_count;
    logic          acq_pulse;
    logic          seq_done;
    logic          timeout_err;

    vinstru_acq_sequencer #(.RST_CYCLES(RC), .CNT_W(CW)) dut (
        .axi_aclk       (clk),
        .axi_aresetn    (rstn),
        .start          (start),
        .abort          (abort),
        .num_acq        (num_acq),
        .gap_cycles     (gap_cycles),
        .timeout_cycles (timeout_cycles),
        .vinstru_done   (done),
        .vinstru_run    (vinstru_run),
        .vinstru_reset  (vinstru_reset),
        .busy           (busy),
        .acq_count      (acq_count),
        .acq_pulse      (acq_pulse),
        .seq_done       (seq_done),
        .timeout_err    (timeout_err)
    );

    // Narrow-counter instance for saturation; its vinstru answers done at once
    logic       start_s;
    logic       abort_s;
    logic       run_s;
    logic       reset_s;
    logic       busy_s;
    logic [3:0] count_s;
    logic       pulse_s;
    logic       seqd_s;
    logic       tmo_s;

    vinstru_acq_sequencer #(.RST_CYCLES(RC), .CNT_W(4)) dut_sat (
        .axi_aclk       (clk),
        .axi_aresetn    (rstn),
        .start          (start_s),
        .abort          (abort_s),
        .num_acq        (4'd0),
        .gap_cycles     (32'd0),
        .timeout_cycles (32'd0),
        .vinstru_done   (run_s),
        .vinstru_run    (run_s),
        .vinstru_reset  (reset_s),
        .busy           (busy_s),
        .acq_count      (count_s),
        .acq_pulse      (pulse_s),
        .seq_done       (seqd_s),
        .timeout_err    (tmo_s)
    );

    // ---------------- scoreboard state ----------------
    logic [35:0] exp_q[$];
    logic [31:0] plan_d[$];
    logic [31:0] delay_q[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic string kname(input logic [3:0] k);
        case (k)
            K_START: return "start";
            K_RST:   return "reset_width";
            K_RUN:   return "run_width";
            K_PULSE: return "acq_pulse_count";
            K_GAP:   return "gap_length";
            K_END:   return "end_status";
            default: return "unknown";
        endcase
    endfunction

    task automatic observe(input logic [3:0] k, input logic [31:0] v);
        logic [35:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_%s: got %0d, expected no event", kname(k), v);
        end else begin
            e = exp_q.pop_front();
            check({"event_", kname(k)}, {k, v}, e);
        end
    endtask

    // Reference model: expand one sequence plan into its event list
    task automatic build_expect(input int n, input int g, input int t,
                                input int ab_acq, input int ab_age);
        logic [15:0] cnt;
        logic [31:0] d;
        cnt = 16'd0;
        exp_q.push_back({K_START, 32'h0004_0000}); // reset high, flags and count clear
        for (int i = 0; i < 1000; i++) begin
            d = (i < plan_d.size()) ? plan_d[i] : 32'hFFFF_FFFF;
            if (i > 0) exp_q.push_back({K_GAP, 32'(g)});
            exp_q.push_back({K_RST, 32'(RC)});
            if (i == ab_acq) begin
                exp_q.push_back({K_RUN, 32'(ab_age + 1)});
                exp_q.push_back({K_END, 14'd0, 2'b00, cnt});
                break;
            end
            if (t != 0 && d >= 32'(t)) begin
                exp_q.push_back({K_RUN, 32'(t)});
                exp_q.push_back({K_END, 14'd0, 2'b01, cnt});
                break;
            end
            exp_q.push_back({K_RUN, d + 32'd1});
            if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
            exp_q.push_back({K_PULSE, 16'd0, cnt});
            if (n != 0 && cnt == 16'(n)) begin
                exp_q.push_back({K_END, 14'd0, 2'b10, cnt});
                break;
            end
        end
    endtask

    // ---------------- vinstru model / abort driver ----------------
    int          acq_idx = -1;
    int          abort_acq = -1;
    int          abort_age = 0;
    logic [31:0] age = 32'd0;
    logic [31:0] cur_d = 32'hFFFF_FFFF;
    logic        drv_run_p = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            done = 1'b0;
            abort = 1'b0;
            drv_run_p = 1'b0;
        end else begin
            abort = 1'b0;
            if (vinstru_run && !drv_run_p) begin
                acq_idx++;
                age = 32'd0;
                cur_d = (delay_q.size() != 0) ? delay_q.pop_front() : 32'hFFFF_FFFF;
            end else if (vinstru_run) begin
                age = age + 32'd1;
            end
            if (vinstru_run && age == cur_d) done = 1'b1;
            if (vinstru_run && acq_idx == abort_acq && age == 32'(abort_age)) abort = 1'b1;
            if (vinstru_reset) done = 1'b0;   // a reset pulse clears a stale done
            drv_run_p = vinstru_run;
        end
    end

    // ---------------- monitor ----------------
    logic m_run_p = 1'b0;
    logic m_rst_p = 1'b0;
    logic m_busy_p = 1'b0;
    logic gap_armed = 1'b0;
    int   rst_w = 0;
    int   run_w = 0;
    int   gap_ctr = 0;
    int   sat_pulses = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            m_run_p = 1'b0;
            m_rst_p = 1'b0;
            m_busy_p = 1'b0;
            gap_armed = 1'b0;
        end else begin
            gap_ctr++;
            if (busy && !m_busy_p)
                observe(K_START, {13'd0, vinstru_reset, seq_done, timeout_err, acq_count});
            if (vinstru_run && !m_run_p)
                check("run_follows_reset", {34'd0, m_rst_p, vinstru_reset}, 36'b10);
            if (vinstru_run) run_w = m_run_p ? run_w + 1 : 1;
            if (!vinstru_run && m_run_p) begin
                observe(K_RUN, 32'(run_w));
                gap_ctr = 0;
                gap_armed = 1'b1;
            end
            if (acq_pulse) observe(K_PULSE, {16'd0, acq_count});
            if (vinstru_reset && !m_rst_p && gap_armed) begin
                observe(K_GAP, 32'(gap_ctr));
                gap_armed = 1'b0;
            end
            if (vinstru_reset) rst_w = m_rst_p ? rst_w + 1 : 1;
            if (!vinstru_reset && m_rst_p) observe(K_RST, 32'(rst_w));
            if (!busy && m_busy_p) begin
                observe(K_END, {14'd0, seq_done, timeout_err, acq_count});
                gap_armed = 1'b0;
            end
            if (pulse_s) begin
                sat_pulses++;
                check("sat_count", {32'd0, count_s},
                      (sat_pulses >= 15) ? 36'd15 : 36'(sat_pulses));
            end
            m_run_p = vinstru_run;
            m_rst_p = vinstru_reset;
            m_busy_p = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_seq(input int n, input int g, input int t,
                           input int ab_acq, input int ab_age, input bit disturb);
        int k;
        build_expect(n, g, t, ab_acq, ab_age);
        delay_q = plan_d;
        acq_idx = -1;
        abort_acq = ab_acq;
        abort_age = ab_age;
        @(negedge clk);
        num_acq = CW'(n);
        gap_cycles = 32'(g);
        timeout_cycles = 32'(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // settings are latched; changing them now must not matter
        num_acq = CW'($urandom);
        gap_cycles = $urandom;
        timeout_cycles = $urandom;
        if (disturb) begin
            repeat (6) @(negedge clk);
            num_acq = CW'(5);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("sequence_finished_in_budget", {35'd0, busy}, 36'd0);
        if (busy) begin
            rstn = 1'b0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("all_events_seen", 36'(exp_q.size()), 36'd0);
        exp_q.delete();
    endtask

    initial begin
        int k;
        int n;
        int g;
        int t;
        int ab;
        int ab_age;
        int lim;
        rstn = 1'b0;
        start = 1'b1;
        num_acq = '0;
        gap_cycles = 32'd0;
        timeout_cycles = 32'd0;
        start_s = 1'b0;
        abort_s = 1'b0;

        // reset with start held high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  {14'd0, vinstru_run, vinstru_reset, busy, acq_count, acq_pulse, seq_done, timeout_err},
                  36'd0);
        end
        rstn = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", {33'd0, busy, vinstru_reset, vinstru_run}, 36'd0);
        end

        // saturation on the 4-bit instance
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        k = 0;
        while (sat_pulses < 20 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("sat_pulses_continue", 36'(sat_pulses >= 20), 36'd1);
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        @(negedge clk);
        check("sat_abort_idle", {31'd0, busy_s, count_s}, {31'd0, 1'b0, 4'hF});

        // three acquisitions, gap 10, done 20 cycles into each run
        plan_d = '{32'd20, 32'd20, 32'd20};
        run_seq(3, 10, 0, -1, 0, 1'b0);

        // timeout 50 with done never arriving
        plan_d.delete();
        run_seq(1, 0, 50, -1, 0, 1'b0);

        // a new start clears timeout_err
        plan_d = '{32'd3};
        run_seq(1, 0, 0, -1, 0, 1'b0);

        // continuous, back-to-back; abort together with done in the 2nd run
        plan_d = '{32'd5, 32'd7};
        run_seq(0, 0, 0, 1, 7, 1'b0);

        // start re-pulsed and num_acq changed to 5 while busy
        plan_d = '{32'd8, 32'd8};
        run_seq(2, 3, 0, -1, 0, 1'b1);

        // done on the last allowed cycle, then a timeout on the next shot
        plan_d = '{32'd9, 32'd10};
        run_seq(3, 2, 10, -1, 0, 1'b0);

        // randomized sequences
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 4);
            g = $urandom_range(0, 6);
            t = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 12) : 0;
            plan_d.delete();
            for (int i = 0; i < n; i++) plan_d.push_back(32'($urandom_range(0, 12)));
            ab = -1;
            ab_age = 0;
            if ($urandom_range(0, 3) == 0) begin
                ab = $urandom_range(0, n - 1);
                lim = int'(plan_d[ab]);
                if (t != 0 && lim > t - 1) lim = t - 1;
                ab_age = $urandom_range(0, lim);
            end
            run_seq(n, g, t, ab, ab_age, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vinstru_acq_sequencer.md
Name: vinstru_acq_sequencer

Overview:
Sequences the virtual instrument (vinstru) through a programmed number of acquisitions without per-shot software involvement. Each acquisition is a vinstru reset pulse, run held until done, then a programmable idle gap. Control and status are wired to the mem_regfile register bank; the vinstru run/reset inputs are driven here instead of directly from register bits. Runs in the PCIe AXI clock domain.

Parameters:
RST_CYCLES, 4, cycles vinstru_reset is held high at the start of each acquisition (>=1)
CNT_W, 16, width of num_acq and acq_count

Ports:
axi_aclk  input  1  clock
axi_aresetn  input  1  reset; synchronous to axi_aclk, active-low
start  input  1  single-cycle pulse; begins a sequence (ignored while busy)
abort  input  1  single-cycle pulse; terminates the sequence
num_acq  input  CNT_W  acquisitions per sequence; 0 = continuous until abort
gap_cycles  input  32  idle cycles between acquisitions
timeout_cycles  input  32  max cycles in RUN waiting for done; 0 = no timeout
vinstru_done  input  1  done from vinstru (level)
vinstru_run  output  1  run to vinstru
vinstru_reset  output  1  reset to vinstru
busy  output  1  high in any state except IDLE
acq_count  output  CNT_W  acquisitions completed in current/last sequence
acq_pulse  output  1  one-cycle pulse per completed acquisition
seq_done  output  1  sticky; set on normal completion, cleared by next accepted start
timeout_err  output  1  sticky; set on timeout, cleared by next accepted start

Behaviour:
- Reset (axi_aresetn=0 at a clock edge): state IDLE; all outputs 0; internal counters 0. Takes priority over all other inputs.
- States: IDLE, RST, RUN, GAP. All outputs are registered.
- Latching: num_acq, gap_cycles and timeout_cycles are captured on the cycle start is accepted. Later input changes have no effect until the next start.
- IDLE: start=1 -> RST next cycle. acq_count, seq_done and timeout_err clear to 0 on the same edge. start while busy is ignored.
- RST: vinstru_reset=1 for exactly RST_CYCLES cycles, then RUN.
  - Timing: start accepted at edge t -> busy and vinstru_reset high from t+1 through t+RST_CYCLES; vinstru_run high from t+RST_CYCLES+1.
- RUN: vinstru_run=1 and a 32-bit timer counts from 0.
  - vinstru_done sampled 1: vinstru_run drops next cycle; acq_pulse=1 for one cycle; acq_count increments.
  - If num_acq!=0 and the new count equals num_acq: go to IDLE and set seq_done.
  - Otherwise go to GAP, or go straight to RST if gap_cycles=0.
- Timeout: timeout_cycles!=0 and the timer reaches timeout_cycles with done still 0 -> IDLE, timeout_err=1, acq_count unchanged, vinstru_run=0 next cycle. If done and timeout expiry fall in the same cycle, done wins.
- GAP: all vinstru outputs 0 for exactly gap_cycles cycles, then RST.
- Continuous mode (num_acq=0): acq_count saturates at all-ones and does not wrap; acq_pulse keeps pulsing.
- abort: from any non-IDLE state -> IDLE next cycle; vinstru_run and vinstru_reset go to 0 on that edge.
  - seq_done and timeout_err are not set; acq_count is held.
  - abort has priority over done, timeout and start in the same cycle.
  - abort in IDLE has no effect.
- vinstru_done is never sampled outside RUN. A stale done left high is cleared by the RST pulse before RUN starts.

Test Plan:
- Reset: hold axi_aresetn=0 for 3 cycles with start=1 -> all outputs 0, state IDLE; release -> still idle, no start accepted from held input.
- num_acq=3, gap=10, timeout=0, RST_CYCLES=4, done asserted 20 cycles after each run rise -> 3 reset pulses of width 4, 3 acq_pulses, gap of 10 between run fall and next reset rise, acq_count=3, seq_done=1, busy=0.
- timeout=50, done never asserted -> run high exactly 50 cycles, then timeout_err=1, acq_count=0, busy=0; a new start clears timeout_err.
- num_acq=0, gap=0 -> back-to-back acquisitions; abort during 2nd RUN with done=1 in the same cycle -> IDLE next cycle, acq_count=1, seq_done=0, no 2nd acq_pulse.
- start re-pulsed while busy, and num_acq changed mid-sequence from 2 to 5 -> ignored; sequence completes after 2.
- Saturation: force acq_count near all-ones (CNT_W=4 build, num_acq=0) -> holds at 15 and does not wrap, acq_pulse still fires.
